mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, memory address width.
REQ-002 SHALL have parameter DW, default 8, memory data width.
REQ-003 SHALL have parameter LOCK_MAX, default 8, maximum consecutive locked grants to one requester.
REQ-004 SHALL have port clock  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port mode  in  1  1 = program mode (CPU blocked), 0 = run mode (both eligible).
REQ-007 SHALL have ports cpu_req/cpu_wr/cpu_lock  in  1 each  CPU request, write, lock.
REQ-008 SHALL have ports cpu_adrs  in  AW  and cpu_wdata  in  DW  CPU command.
REQ-009 SHALL have ports cpu_gnt/cpu_rvalid  out  1  and cpu_rdata  out  DW  CPU accept, read return.
REQ-010 SHALL have ports prg_req/prg_wr/prg_lock  in  1  and prg_adrs  in  AW, prg_wdata  in  DW  programmer command.
REQ-011 SHALL have ports prg_gnt/prg_rvalid  out  1  and prg_rdata  out  DW  programmer accept, read return.
REQ-012 SHALL have ports mem_adrs  out  AW, mem_data  out  DW, mem_wr_en  out  1  registered memory command.
REQ-013 SHALL have port mem_q  in  DW  synchronous-RAM read data.
REQ-014 SHALL have port owner  out  2  lock owner: 00 none, 01 CPU, 10 programmer.

Function
REQ-015 SHALL assert at most one gnt per cycle; gnt is combinational from req/state/mode; command accepted when req and gnt are high in the same cycle.
REQ-016 SHALL, with mode=1, hold cpu_gnt at 0 regardless of other inputs.
REQ-017 SHALL, in state IDLE with a single eligible requester, grant it.
REQ-018 SHALL, in IDLE with both eligible, grant the requester not granted last (round-robin); last-winner register resets to programmer, so the CPU wins the first contention.
REQ-019 SHALL enter LOCK_CPU or LOCK_PRG when a grant is accepted with that requester's lock=1; owner reflects the state.
REQ-020 SHALL, in LOCK_x, grant only x; the other requester waits.
REQ-021 SHALL return from LOCK_x to IDLE when x is granted with lock=0, or x has req=0 and lock=0.
REQ-022 SHALL count consecutive locked grants; when the count reaches LOCK_MAX and the other requester is requesting, SHALL force IDLE, grant the other next cycle, and clear the count.
REQ-023 SHALL force LOCK_CPU to IDLE in the cycle mode is 1; the CPU lock is broken, not deferred.
REQ-024 SHALL, on accepted command in cycle N, drive mem_adrs/mem_data/mem_wr_en in cycle N+1 from the winner's adrs/wdata/wr.
REQ-025 SHALL pulse mem_wr_en for exactly one cycle per accepted write; mem_wr_en=0 and mem_adrs/mem_data hold previous values when nothing is accepted.
REQ-026 SHALL, for an accepted read in cycle N, pulse the winner's rvalid in cycle N+2, aligned with mem_q; this needs a 2-stage tag pipeline {valid, who}.
REQ-027 SHALL drive cpu_rdata and prg_rdata directly from mem_q; data is meaningful only with rvalid.
REQ-028 SHALL sustain one accepted command per cycle; back-to-back reads return in order at one per cycle.
REQ-029 SHALL deliver in-flight read returns even if mode or lock state changes after acceptance.

Reset
REQ-030 SHALL, on reset, set state IDLE, owner=00, last-winner=programmer, lock count=0, and mem_adrs/mem_data/mem_wr_en=0.
REQ-031 SHALL clear the rvalid pipeline on reset; reads in flight are dropped with no rvalid. gnt is 0 during the reset cycle.

Structure
REQ-032 SHALL place owner encodings, FSM state encodings and AW/DW defaults in shared include cdec_mem_defs.vh, also used by memory_programmer-side logic.
REQ-033 SHALL implement the read-return tag pipeline as sub-module rd_return_pipe (2-stage {valid, who}); arbitration/FSM stay in the top.

Verification
REQ-034 SHALL cover contention: mode=0, both req reads from reset (cpu_adrs=0x10, prg_adrs=0x20) -> cpu_gnt first, prg_gnt next cycle; mem_adrs 0x10 then 0x20; cpu_rvalid and prg_rvalid each two cycles after their grant.
REQ-035 SHALL cover program mode: mode=1, both req; prg writes 0x5A to 0x03 -> cpu_gnt never 1; mem_wr_en one cycle with mem_adrs=0x03, mem_data=0x5A.
REQ-036 SHALL cover lock: CPU lock=1 for 3 reads while prg_req=1 -> owner=01, prg_gnt=0 throughout; CPU lock=0 on the 4th grant -> prg granted next cycle.
REQ-037 SHALL cover starvation: CPU lock held for 12 grants, prg_req=1 -> after 8 CPU grants, prg_gnt=1 for one cycle, CPU then resumes.
REQ-038 SHALL cover mode break: LOCK_CPU active, mode to 1 -> owner=00 same cycle, cpu_gnt=0, prg granted.
REQ-039 SHALL cover reset mid-read: read accepted cycle N, reset in N+1 -> no rvalid in N+2; all outputs 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the CPU / programmer memory port arbiter and the
// programmer-side logic that reads the lock owner.
package mem_port_arbiter_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_PRG  = 2'b10
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_LOCK_CPU = 2'b01,
        ST_LOCK_PRG = 2'b10
    } arb_state_e;

    typedef enum logic {
        WHO_CPU = 1'b0,
        WHO_PRG = 1'b1
    } who_e;

    typedef struct packed {
        logic vld;
        who_e who;
    } rd_tag_t;

    function automatic owner_e state_owner(input arb_state_e s);
        case (s)
            ST_LOCK_CPU: return OWN_CPU;
            ST_LOCK_PRG: return OWN_PRG;
            default:     return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rd_return_pipe.sv
// Two-stage {valid, who} tag pipeline: a read accepted in cycle N raises the
// owning requester's rvalid in N+2, lined up with synchronous-RAM data.
module rd_return_pipe
    import mem_port_arbiter_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic push_vld,
    input  who_e push_who,
    output logic cpu_rvalid,
    output logic prg_rvalid
);

    rd_tag_t s1_q;
    rd_tag_t s2_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= '{vld: push_vld, who: push_who};
            s2_q <= s1_q;
        end
    end

    assign cpu_rvalid = s2_q.vld && (s2_q.who == WHO_CPU);
    assign prg_rvalid = s2_q.vld && (s2_q.who == WHO_PRG);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter (CPU, programmer) onto one synchronous RAM port with
// round-robin, bounded bus locking and a program mode that shuts the CPU out.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int LOCK_MAX = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          mode,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic          cpu_lock,
    input  logic [AW-1:0] cpu_adrs,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          prg_req,
    input  logic          prg_wr,
    input  logic          prg_lock,
    input  logic [AW-1:0] prg_adrs,
    input  logic [DW-1:0] prg_wdata,
    output logic          prg_gnt,
    output logic          prg_rvalid,
    output logic [DW-1:0] prg_rdata,
    output logic [AW-1:0] mem_adrs,
    output logic [DW-1:0] mem_data,
    output logic          mem_wr_en,
    input  logic [DW-1:0] mem_q,
    output logic [1:0]    owner
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    arb_state_e    state_q, state_d, eff_state;
    who_e          last_q, last_d, win_who;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [AW-1:0] mem_adrs_q;
    logic [DW-1:0] mem_data_q;
    logic          mem_wr_en_q;
    logic          cpu_elig, prg_elig;
    logic          cpu_gnt_c, prg_gnt_c, acc;
    logic          win_lock, win_wr;
    logic [AW-1:0] win_adrs;
    logic [DW-1:0] win_wdata;

    // Program mode breaks a CPU lock in the very cycle it rises.
    always_comb begin
        eff_state = state_q;
        if (reset || (state_q == ST_LOCK_CPU && mode)) begin
            eff_state = ST_IDLE;
        end
    end

    assign cpu_elig = cpu_req && !mode && !reset;
    assign prg_elig = prg_req && !reset;

    always_comb begin
        cpu_gnt_c = 1'b0;
        prg_gnt_c = 1'b0;
        case (eff_state)
            ST_LOCK_CPU: cpu_gnt_c = cpu_elig;
            ST_LOCK_PRG: prg_gnt_c = prg_elig;
            default: begin
                if (cpu_elig && prg_elig) begin
                    cpu_gnt_c = (last_q == WHO_PRG);
                    prg_gnt_c = (last_q == WHO_CPU);
                end else begin
                    cpu_gnt_c = cpu_elig;
                    prg_gnt_c = prg_elig;
                end
            end
        endcase
    end

    assign acc       = cpu_gnt_c || prg_gnt_c;
    assign win_who   = prg_gnt_c ? WHO_PRG : WHO_CPU;
    assign win_lock  = prg_gnt_c ? prg_lock  : cpu_lock;
    assign win_wr    = prg_gnt_c ? prg_wr    : cpu_wr;
    assign win_adrs  = prg_gnt_c ? prg_adrs  : cpu_adrs;
    assign win_wdata = prg_gnt_c ? prg_wdata : cpu_wdata;
    assign cnt_inc   = (cnt_q == CW'(LOCK_MAX)) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d = eff_state;
        last_d  = acc ? win_who : last_q;
        cnt_d   = cnt_q;
        case (eff_state)
            ST_LOCK_CPU: begin
                if (cpu_gnt_c) begin
                    if (cpu_lock) cnt_d = cnt_inc;
                    else          state_d = ST_IDLE;
                end else if (!cpu_req && !cpu_lock) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK_PRG: begin
                if (prg_gnt_c) begin
                    if (prg_lock) cnt_d = cnt_inc;
                    else          state_d = ST_IDLE;
                end else if (!prg_req && !prg_lock) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (acc && win_lock) begin
                    state_d = prg_gnt_c ? ST_LOCK_PRG : ST_LOCK_CPU;
                    cnt_d   = CW'(1);
                end
            end
        endcase
        // Starvation guard: a waiting requester gets the bus once the lock quota is spent.
        if (state_d == ST_LOCK_CPU && cnt_d >= CW'(LOCK_MAX) && prg_req) begin
            state_d = ST_IDLE;
        end
        if (state_d == ST_LOCK_PRG && cnt_d >= CW'(LOCK_MAX) && cpu_req && !mode) begin
            state_d = ST_IDLE;
        end
        if (state_d == ST_IDLE) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_q      <= WHO_PRG;
            cnt_q       <= '0;
            mem_adrs_q  <= '0;
            mem_data_q  <= '0;
            mem_wr_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            mem_wr_en_q <= acc && win_wr;
            if (acc) begin
                mem_adrs_q <= win_adrs;
                mem_data_q <= win_wdata;
            end
        end
    end

    rd_return_pipe u_rd_return_pipe (
        .clock      (clock),
        .reset      (reset),
        .push_vld   (acc && !win_wr),
        .push_who   (win_who),
        .cpu_rvalid (cpu_rvalid),
        .prg_rvalid (prg_rvalid)
    );

    assign cpu_gnt   = cpu_gnt_c;
    assign prg_gnt   = prg_gnt_c;
    assign owner     = state_owner(eff_state);
    assign mem_adrs  = mem_adrs_q;
    assign mem_data  = mem_data_q;
    assign mem_wr_en = mem_wr_en_q;
    assign cpu_rdata = mem_q;
    assign prg_rdata = mem_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal checks plus a
// transaction-level model compared against the outputs every cycle.
module tb_mem_port_arbiter;

    localparam int LOCK_MAX = 8;

    logic       clk = 1'b0;
    logic       reset, mode;
    logic       cpu_req, cpu_wr, cpu_lock, prg_req, prg_wr, prg_lock;
    logic [7:0] cpu_adrs, cpu_wdata, prg_adrs, prg_wdata;
    logic       cpu_gnt, cpu_rvalid, prg_gnt, prg_rvalid, mem_wr_en;
    logic [7:0] cpu_rdata, prg_rdata, mem_adrs, mem_data;
    logic [7:0] mem_q = 8'h00;
    logic [1:0] owner;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(8), .DW(8), .LOCK_MAX(LOCK_MAX)) dut (
        .clock(clk), .reset(reset), .mode(mode),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_lock(cpu_lock),
        .cpu_adrs(cpu_adrs), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .prg_req(prg_req), .prg_wr(prg_wr), .prg_lock(prg_lock),
        .prg_adrs(prg_adrs), .prg_wdata(prg_wdata),
        .prg_gnt(prg_gnt), .prg_rvalid(prg_rvalid), .prg_rdata(prg_rdata),
        .mem_adrs(mem_adrs), .mem_data(mem_data), .mem_wr_en(mem_wr_en),
        .mem_q(mem_q), .owner(owner)
    );

    // Synchronous RAM behind the port; preloaded with adrs ^ 0xA5 on the first edge.
    logic [7:0] ram [256];
    bit         ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'hA5;
            ram_ready <= 1'b1;
        end else begin
            mem_q <= ram[mem_adrs];
            if (mem_wr_en) ram[mem_adrs] <= mem_data;
        end
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk2(input string nm, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        int         due;
        bit         prg;
        logic [7:0] dat;
    } rd_t;

    rd_t        pend[$];
    logic [7:0] mram [256];
    int         cyc    = 0;
    int         m_own  = 0;   // 0 nobody, 1 CPU, 2 programmer holds the lock
    int         m_last = 2;   // last winner: 1 CPU, 2 programmer
    int         m_cnt  = 0;
    logic       e_wr   = 1'b0;
    logic [7:0] e_adrs = 8'h00;
    logic [7:0] e_data = 8'h00;

    always @(negedge clk) begin : model_cmp
        int         own;
        bit         cok, pok, gc, gp, acc, wl, ww, xg, xreq, xlock, other;
        logic [7:0] wa, wd, e_rd;
        bit         e_rc, e_rp;

        if (cyc == 0) for (int i = 0; i < 256; i++) mram[i] = 8'(i) ^ 8'hA5;

        chk1("mem_wr_en", mem_wr_en, e_wr);
        chk8("mem_adrs", mem_adrs, e_adrs);
        chk8("mem_data", mem_data, e_data);

        e_rc = 1'b0; e_rp = 1'b0; e_rd = 8'h00;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            e_rc = !pend[0].prg;
            e_rp = pend[0].prg;
            e_rd = pend[0].dat;
            pend.delete(0);
        end
        chk1("cpu_rvalid", cpu_rvalid, e_rc);
        chk1("prg_rvalid", prg_rvalid, e_rp);
        if (e_rc) chk8("cpu_rdata", cpu_rdata, e_rd);
        if (e_rp) chk8("prg_rdata", prg_rdata, e_rd);

        own = m_own;
        if (reset || (own == 1 && mode)) own = 0;
        cok = cpu_req && !mode && !reset;
        pok = prg_req && !reset;
        gc = 1'b0; gp = 1'b0;
        if (own == 1)          gc = cok;
        else if (own == 2)     gp = pok;
        else if (cok && pok) begin
            gc = (m_last == 2);
            gp = !gc;
        end else begin
            gc = cok;
            gp = pok;
        end
        chk1("cpu_gnt", cpu_gnt, gc);
        chk1("prg_gnt", prg_gnt, gp);
        chk2("owner", owner, 2'(own));

        if (reset) begin
            m_own = 0; m_last = 2; m_cnt = 0;
            e_wr = 1'b0; e_adrs = 8'h00; e_data = 8'h00;
            pend.delete();
        end else begin
            acc = gc || gp;
            wl  = gp ? prg_lock  : cpu_lock;
            ww  = gp ? prg_wr    : cpu_wr;
            wa  = gp ? prg_adrs  : cpu_adrs;
            wd  = gp ? prg_wdata : cpu_wdata;
            e_wr = acc && ww;
            if (acc) begin
                e_adrs = wa;
                e_data = wd;
                m_last = gp ? 2 : 1;
                if (ww) mram[wa] = wd;
                else    pend.push_back('{due: cyc + 2, prg: gp, dat: mram[wa]});
            end
            if (own == 0) begin
                m_own = (acc && wl) ? (gp ? 2 : 1) : 0;
                m_cnt = 1;
            end else begin
                xg    = (own == 1) ? gc : gp;
                xreq  = (own == 1) ? cpu_req  : prg_req;
                xlock = (own == 1) ? cpu_lock : prg_lock;
                m_own = own;
                if (xg && xlock)                 m_cnt = (m_cnt < LOCK_MAX) ? m_cnt + 1 : m_cnt;
                else if (xg || (!xreq && !xlock)) m_own = 0;
            end
            other = (m_own == 1) ? prg_req : (cpu_req && !mode);
            if (m_own != 0 && m_cnt >= LOCK_MAX && other) m_own = 0;
            if (m_own == 0) m_cnt = 0;
        end
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    task automatic drv(input bit cr, input bit cw, input bit cl, input logic [7:0] ca, input logic [7:0] cd,
                       input bit pr, input bit pw, input bit pl, input logic [7:0] pa, input logic [7:0] pd,
                       input bit md);
        cpu_req = cr; cpu_wr = cw; cpu_lock = cl; cpu_adrs = ca; cpu_wdata = cd;
        prg_req = pr; prg_wr = pw; prg_lock = pl; prg_adrs = pa; prg_wdata = pd;
        mode = md;
    endtask

    task automatic idle();
        drv(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drv(1, 0, 0, 8'h10, 8'h00, 1, 0, 0, 8'h20, 8'h00, 0);
        @(negedge clk);
        chk1("rst_cpu_gnt", cpu_gnt, 1'b0);
        chk1("rst_prg_gnt", prg_gnt, 1'b0);
        chk2("rst_owner", owner, 2'b00);
        chk1("rst_mem_wr_en", mem_wr_en, 1'b0);
        tick();
        reset = 1'b0;

        // Contention from reset: CPU wins first, programmer next.
        drv(1, 0, 0, 8'h10, 8'h00, 1, 0, 0, 8'h20, 8'h00, 0);
        @(negedge clk);
        chk1("cont_cpu_gnt", cpu_gnt, 1'b1);
        chk1("cont_prg_wait", prg_gnt, 1'b0);
        tick();
        drv(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h20, 8'h00, 0);
        @(negedge clk);
        chk1("cont_prg_gnt", prg_gnt, 1'b1);
        chk8("cont_adrs_cpu", mem_adrs, 8'h10);
        tick();
        idle();
        @(negedge clk);
        chk8("cont_adrs_prg", mem_adrs, 8'h20);
        chk1("cont_cpu_rvalid", cpu_rvalid, 1'b1);
        chk8("cont_cpu_rdata", cpu_rdata, 8'hB5);
        tick();
        @(negedge clk);
        chk1("cont_prg_rvalid", prg_rvalid, 1'b1);
        chk8("cont_prg_rdata", prg_rdata, 8'h85);
        tick();

        // Program mode: CPU shut out, programmer writes 0x5A to 0x03.
        drv(1, 0, 0, 8'h11, 8'h00, 1, 1, 0, 8'h03, 8'h5A, 1);
        @(negedge clk);
        chk1("pm_cpu_gnt0", cpu_gnt, 1'b0);
        chk1("pm_prg_gnt", prg_gnt, 1'b1);
        tick();
        drv(1, 0, 0, 8'h11, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1);
        @(negedge clk);
        chk1("pm_cpu_gnt1", cpu_gnt, 1'b0);
        chk1("pm_wr_en", mem_wr_en, 1'b1);
        chk8("pm_adrs", mem_adrs, 8'h03);
        chk8("pm_data", mem_data, 8'h5A);
        tick();
        @(negedge clk);
        chk1("pm_wr_pulse_end", mem_wr_en, 1'b0);
        tick();
        idle();
        tick();

        // Lock: three locked CPU reads, unlocked fourth, then programmer.
        for (int k = 1; k <= 5; k++) begin
            drv(1, 0, k <= 3, 8'(8'h30 + k), 8'h00, 1, 0, 0, 8'h03, 8'h00, 0);
            @(negedge clk);
            chk1("lock_prg_gnt", prg_gnt, k == 5);
            if (k >= 2 && k <= 4) chk2("lock_owner", owner, 2'b01);
            tick();
        end
        idle();
        tick();

        // Starvation: CPU keeps its lock for 12 grants while the programmer waits.
        for (int k = 1; k <= 15; k++) begin
            drv(k <= 13, 0, k <= 13, 8'(k), 8'h00, 1, 0, 0, 8'h50, 8'h00, 0);
            @(negedge clk);
            if (k <= 13) begin
                chk1("starve_cpu_gnt", cpu_gnt, k != 9);
                chk1("starve_prg_gnt", prg_gnt, k == 9);
            end else begin
                chk1("starve_tail_prg", prg_gnt, k == 15);
            end
            if (k == 9) chk2("starve_owner", owner, 2'b00);
            tick();
        end
        idle();
        tick();

        // Mode rising during a CPU lock breaks it immediately.
        drv(1, 0, 1, 8'h60, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
        @(negedge clk);
        chk1("brk_cpu_gnt", cpu_gnt, 1'b1);
        tick();
        @(negedge clk);
        chk2("brk_owner_locked", owner, 2'b01);
        tick();
        drv(1, 0, 1, 8'h61, 8'h00, 1, 1, 0, 8'h44, 8'h77, 1);
        @(negedge clk);
        chk2("brk_owner", owner, 2'b00);
        chk1("brk_cpu_gnt0", cpu_gnt, 1'b0);
        chk1("brk_prg_gnt", prg_gnt, 1'b1);
        tick();
        idle();
        tick();

        // Reset one cycle after a read is accepted drops the return.
        drv(1, 0, 0, 8'h44, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
        @(negedge clk);
        chk1("rr_cpu_gnt", cpu_gnt, 1'b1);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk1("rr_gnt_in_reset", cpu_gnt, 1'b0);
        tick();
        reset = 1'b0;
        idle();
        @(negedge clk);
        chk1("rr_no_rvalid", cpu_rvalid, 1'b0);
        chk1("rr_no_prg_rvalid", prg_rvalid, 1'b0);
        chk8("rr_adrs", mem_adrs, 8'h00);
        chk8("rr_data", mem_data, 8'h00);
        chk1("rr_wr_en", mem_wr_en, 1'b0);
        chk2("rr_owner", owner, 2'b00);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
